// File: rtl/axis_dac_spi_6ch_if.sv
// rtl/axis_dac_spi_6ch_if.sv - six-channel SQ31 sample handshake bundle
// Lane i carries channel i+1 (X, Y, Z, U, A, B).
interface axis_dac_spi_6ch_if;
  logic [5:0][31:0] tdata;
  logic [5:0]       tvalid;
  logic [5:0]       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_dac_spi_6ch.sv
// rtl/axis_dac_spi_6ch.sv - six-lane SQ31-to-DAC SPI transmitter with shared SCLK/SYNC_N/LDAC_N
// Optional power-up control-register frame: AXIS_DAC_SPI_INIT_EN.
module axis_dac_spi_6ch #(
  parameter int SCLK_DIV = 2,
  parameter int SYNC_GAP = 4,
  parameter int LDAC_W   = 2,
  parameter int DAC_BITS = 20
) (
  input  logic                a_clk,
  input  logic                a_reset,
  axis_dac_spi_6ch_if.slave   s_axis,
  output logic                dac_sclk,
  output logic                dac_sync_n,
  output logic [5:0]          dac_sdi,
  output logic                dac_ldac_n,
  output logic                busy,
  output logic [31:0]         frame_count
);

  localparam int WORD_W  = DAC_BITS + 4;
  localparam int BIT_LEN = 2 * SCLK_DIV;
  localparam int CNT_W   = 16;
  localparam int BIT_W   = $clog2(WORD_W);
  localparam logic signed [32:0] CODE_MAX = (33'sd1 <<< (DAC_BITS - 1)) - 33'sd1;
  localparam logic signed [32:0] CODE_MIN = -(33'sd1 <<< (DAC_BITS - 1));

  typedef enum logic [2:0] {
`ifdef AXIS_DAC_SPI_INIT_EN
    ST_INIT,
`endif
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_LDAC
  } state_t;

`ifdef AXIS_DAC_SPI_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
  localparam logic [WORD_W-1:0] INIT_WORD = WORD_W'(24'h200012);
  logic r_init_frame;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [BIT_W-1:0]         r_bit;
  logic [5:0][WORD_W-1:0]   r_shift;
  logic [5:0][31:0]         r_chan;
  logic [5:0][31:0]         w_sel;
  logic [31:0]              r_frame_count;
  logic                     w_bit_end;
  logic                     w_gap_end;
  logic                     w_ldac_end;

  // Round to nearest (add half an LSB), arithmetic shift, clamp to the signed code range.
  function automatic logic [DAC_BITS-1:0] sq31_to_code(input logic [31:0] v);
    logic signed [32:0] w_sum;
    logic signed [32:0] w_shr;
    w_sum = $signed({v[31], v}) + 33'sh800;
    w_shr = w_sum >>> 12;
    if (w_shr > CODE_MAX)
      sq31_to_code = {1'b0, {(DAC_BITS-1){1'b1}}};
    else if (w_shr < CODE_MIN)
      sq31_to_code = {1'b1, {(DAC_BITS-1){1'b0}}};
    else
      sq31_to_code = w_shr[DAC_BITS-1:0];
  endfunction

  assign w_bit_end  = (r_cnt == CNT_W'(BIT_LEN - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(SYNC_GAP - 1));
  assign w_ldac_end = (r_cnt == CNT_W'(LDAC_W - 1));

  always_comb begin
    for (int i = 0; i < 6; i++)
      w_sel[i] = s_axis.tvalid[i] ? s_axis.tdata[i] : r_chan[i];
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) r_state <= RST_STATE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef AXIS_DAC_SPI_INIT_EN
      ST_INIT:  w_state_nxt = ST_SHIFT;
`endif
      ST_IDLE:  if (|s_axis.tvalid) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_bit_end && r_bit == '0) w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (w_gap_end) begin
`ifdef AXIS_DAC_SPI_INIT_EN
          w_state_nxt = r_init_frame ? ST_IDLE : ST_LDAC;
`else
          w_state_nxt = ST_LDAC;
`endif
        end
      end
      ST_LDAC:  if (w_ldac_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      r_cnt         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_chan        <= '0;
      r_frame_count <= '0;
`ifdef AXIS_DAC_SPI_INIT_EN
      r_init_frame  <= 1'b0;
`endif
    end else begin
      case (r_state)
`ifdef AXIS_DAC_SPI_INIT_EN
        ST_INIT: begin
          for (int i = 0; i < 6; i++) r_shift[i] <= INIT_WORD;
          r_cnt        <= '0;
          r_bit        <= BIT_W'(WORD_W - 1);
          r_init_frame <= 1'b1;
        end
`endif
        ST_LOAD: begin
          for (int i = 0; i < 6; i++) begin
            if (s_axis.tvalid[i]) r_chan[i] <= s_axis.tdata[i];
            r_shift[i] <= {4'b0001, sq31_to_code(w_sel[i])};
          end
          r_cnt <= '0;
          r_bit <= BIT_W'(WORD_W - 1);
`ifdef AXIS_DAC_SPI_INIT_EN
          r_init_frame <= 1'b0;
`endif
        end
        ST_SHIFT: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            r_bit <= r_bit - 1'b1;
            for (int i = 0; i < 6; i++) r_shift[i] <= {r_shift[i][WORD_W-2:0], 1'b0};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP:  r_cnt <= w_gap_end ? '0 : r_cnt + 1'b1;
        ST_LDAC: begin
          if (w_ldac_end) begin
            r_cnt         <= '0;
            r_frame_count <= r_frame_count + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // SDI is launched with the first low half of each bit; the DAC samples on the falling edge.
  always_comb begin
    dac_sdi = '0;
    if (r_state == ST_SHIFT)
      for (int i = 0; i < 6; i++) dac_sdi[i] = r_shift[i][WORD_W-1];
  end

  assign dac_sclk      = (r_state == ST_SHIFT) && (r_cnt >= CNT_W'(SCLK_DIV));
  assign dac_sync_n    = (r_state != ST_SHIFT);
  assign dac_ldac_n    = (r_state != ST_LDAC);
  assign busy          = (r_state != ST_IDLE);
  assign frame_count   = r_frame_count;
  assign s_axis.tready = (r_state == ST_LOAD) ? s_axis.tvalid : 6'b0;

endmodule

// File: tb/tb_axis_dac_spi_6ch.sv
// tb/tb_axis_dac_spi_6ch.sv - scoreboard bench for axis_dac_spi_6ch (default build)
module tb_axis_dac_spi_6ch;
  logic        a_clk = 1'b0;
  logic        a_reset = 1'b1;
  logic        dac_sclk, dac_sync_n, dac_ldac_n, busy;
  logic [5:0]  dac_sdi;
  logic [31:0] frame_count;

  axis_dac_spi_6ch_if u_if ();

  axis_dac_spi_6ch u_dut (
    .a_clk       (a_clk),
    .a_reset     (a_reset),
    .s_axis      (u_if),
    .dac_sclk    (dac_sclk),
    .dac_sync_n  (dac_sync_n),
    .dac_sdi     (dac_sdi),
    .dac_ldac_n  (dac_ldac_n),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 a_clk = ~a_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b1;
  logic [5:0][23:0] exp_q [$];

  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: rebuilds each lane word from SDI at SCLK falling edges and checks it against the queue.
  logic [5:0][23:0] cap_w;
  logic [5:0][23:0] exp_w;
  logic [5:0]       last_sdi;
  logic             prev_sclk;
  int               bit_cnt, sync_cnt, ldac_cnt;
  logic [31:0]      exp_fc;

  always @(negedge a_clk) begin
    if (a_reset || !mon_en) begin
      bit_cnt = 0; sync_cnt = 0; ldac_cnt = 0; prev_sclk = 1'b0; cap_w = '0;
      if (a_reset) exp_fc = 0;
    end else begin
      if (!dac_sync_n) begin
        sync_cnt++;
        if (prev_sclk && !dac_sclk) begin
          for (int i = 0; i < 6; i++) cap_w[i] = {cap_w[i][22:0], last_sdi[i]};
          bit_cnt++;
        end
        if (dac_sclk) last_sdi = dac_sdi;
      end else if (sync_cnt != 0) begin
        if (prev_sclk) begin
          for (int i = 0; i < 6; i++) cap_w[i] = {cap_w[i][22:0], last_sdi[i]};
          bit_cnt++;
        end
        chk("frame_bits", bit_cnt, 24);
        chk("sync_low_cycles", sync_cnt, 96);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", exp_q.size(), 1);
        end else begin
          exp_w = exp_q.pop_front();
          for (int i = 0; i < 6; i++)
            chk($sformatf("lane%0d_word", i), cap_w[i], exp_w[i]);
        end
        bit_cnt = 0; sync_cnt = 0; cap_w = '0;
      end
      if (!dac_ldac_n) begin
        ldac_cnt++;
      end else if (ldac_cnt != 0) begin
        chk("ldac_low_cycles", ldac_cnt, 2);
        exp_fc = exp_fc + 1;
        chk("frame_count_after_ldac", frame_count, exp_fc);
        ldac_cnt = 0;
      end
      prev_sclk = dac_sclk;
    end
  end

  task automatic wait_tready();
    int k;
    k = 0;
    @(negedge a_clk);
    while (u_if.tready == 6'b0 && k < 300) begin
      @(negedge a_clk);
      k++;
    end
    chk("tready_seen", (u_if.tready != 6'b0), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge a_clk);
    while (busy && k < 300) begin
      @(negedge a_clk);
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic send(input logic [5:0] v);
    @(posedge a_clk); #1;
    u_if.tvalid = v;
    wait_tready();
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b0;
    wait_idle();
  endtask

  int t_prev, ldac_seen;

  initial begin
    u_if.tdata  = '0;
    u_if.tvalid = '0;
    repeat (3) @(posedge a_clk);
    @(negedge a_clk);
    chk("rst_sclk", dac_sclk, 0);
    chk("rst_sync_n", dac_sync_n, 1);
    chk("rst_ldac_n", dac_ldac_n, 1);
    chk("rst_sdi", dac_sdi, 0);
    chk("rst_tready", u_if.tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    @(posedge a_clk); #1;
    a_reset = 1'b0;

    // Frame 1: ch1 only, with latency checks.
    @(posedge a_clk); #1;
    u_if.tdata[0] = 32'h4000_0000;
    u_if.tvalid   = 6'b000001;
    exp_q.push_back({24'h100000, 24'h100000, 24'h100000, 24'h100000, 24'h100000, 24'h140000});
    @(negedge a_clk);
    chk("tready_before_load", u_if.tready, 6'b000000);
    @(negedge a_clk);
    chk("tready_load", u_if.tready, 6'b000001);
    chk("busy_load", busy, 1);
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b0;
    @(negedge a_clk);
    chk("sync_fall_latency", dac_sync_n, 0);
    wait_idle();
    chk("frame_count_1", frame_count, 1);

    // Frame 2: saturation and rounding; ch1 holds its previous value.
    u_if.tdata[1] = 32'h7FFF_FFFF;
    u_if.tdata[2] = 32'h8000_0000;
    u_if.tdata[3] = 32'h0000_07FF;
    u_if.tdata[4] = 32'h0000_0800;
    u_if.tdata[5] = 32'h1000_0000;
    exp_q.push_back({24'h110000, 24'h100001, 24'h100000, 24'h180000, 24'h17FFFF, 24'h140000});
    send(6'b111110);

    // Frame 3: only ch1 refreshed (rounds to -1); data changed mid-SHIFT must not leak in.
    u_if.tdata[0] = 32'hFFFF_F000;
    exp_q.push_back({24'h110000, 24'h100001, 24'h100000, 24'h180000, 24'h17FFFF, 24'h1FFFFF});
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b000001;
    wait_tready();
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b0;
    repeat (20) @(posedge a_clk);
    #1;
    for (int i = 0; i < 6; i++) u_if.tdata[i] = 32'hC000_0000;
    u_if.tvalid = 6'b111111;
    exp_q.push_back({6{24'h1C0000}});
    wait_tready();
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b0;
    wait_idle();
    chk("frame_count_4", frame_count, 4);

    // Abort: reset during bit 12 of SHIFT.
    mon_en = 1'b0;
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b000001;
    wait_tready();
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b0;
    @(negedge a_clk);
    chk("abort_sync_low", dac_sync_n, 0);
    repeat (45) @(posedge a_clk);
    #1;
    a_reset = 1'b1;
    @(negedge a_clk);
    @(negedge a_clk);
    chk("abort_sync_n", dac_sync_n, 1);
    chk("abort_sclk", dac_sclk, 0);
    chk("abort_sdi", dac_sdi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_count", frame_count, 0);
    @(posedge a_clk); #1;
    a_reset = 1'b0;
    ldac_seen = 0;
    repeat (150) begin
      @(negedge a_clk);
      if (!dac_ldac_n) ldac_seen++;
    end
    chk("abort_no_ldac", ldac_seen, 0);
    chk("abort_frame_count_hold", frame_count, 0);
    mon_en = 1'b1;

    // Continuous tvalid on all channels: 10 frames at a 104-cycle period.
    for (int i = 0; i < 6; i++) u_if.tdata[i] = (i + 1) << 24;
    for (int f = 0; f < 10; f++)
      exp_q.push_back({24'h106000, 24'h105000, 24'h104000, 24'h103000, 24'h102000, 24'h101000});
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b111111;
    for (int f = 0; f < 10; f++) begin
      wait_tready();
      if (f > 0) chk("frame_period", cyc - t_prev, 104);
      t_prev = cyc;
    end
    @(posedge a_clk); #1;
    u_if.tvalid = 6'b0;
    wait_idle();
    chk("frame_count_10", frame_count, 10);
    repeat (5) @(negedge a_clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
